// File: rtl/arb_pkg.sv
// Shared constants, types and helpers for the round-robin arbiter.
// Helpers work on a fixed maximum width; callers slice down to NUM_AGENTS.
package arb_pkg;

    localparam int NUM_AGENTS_DEF = 2;
    localparam int MAX_HOLD_DEF   = 4;
    localparam int AGENT_MAX      = 64;
    localparam int AIDX_W         = $clog2(AGENT_MAX);

    typedef logic [AGENT_MAX-1:0] agent_vec_t;
    typedef logic [AIDX_W-1:0]    agent_idx_t;

    typedef struct packed {
        logic       vld;
        agent_idx_t idx;
    } pick_t;

    function automatic agent_vec_t onehot(input agent_idx_t idx);
        agent_vec_t vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Scan from farthest to nearest so the requester closest above ptr wins; ptr itself is last.
    function automatic pick_t rr_pick(input agent_vec_t req, input agent_idx_t ptr, input int n);
        pick_t res;
        int    cand;
        res = '0;
        for (int k = AGENT_MAX; k >= 1; k--) begin
            if (k <= n) begin
                cand = int'(ptr) + k;
                if (cand >= n) begin
                    cand = cand - n;
                end else begin
                    cand = cand;
                end
                if (req[agent_idx_t'(cand)]) begin
                    res.vld = 1'b1;
                    res.idx = agent_idx_t'(cand);
                end else begin
                    res = res;
                end
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational circular priority encoder: first requester above ptr,
// wrapping from NUM_AGENTS-1 back to 0.
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter  int NUM_AGENTS = NUM_AGENTS_DEF,
    localparam int IDX_W      = $clog2(NUM_AGENTS)
) (
    input  logic [NUM_AGENTS-1:0] req,
    input  logic [IDX_W-1:0]      ptr,
    output logic                  vld,
    output logic [IDX_W-1:0]      idx
);

    agent_vec_t req_ext;
    agent_idx_t ptr_ext;
    pick_t      pick;
    logic       unused_idx_hi;

    // Widen to the helper's fixed width and narrow the result back.
    always_comb begin
        req_ext                 = '0;
        req_ext[NUM_AGENTS-1:0] = req;
        ptr_ext                 = agent_idx_t'(ptr);
        pick                    = rr_pick(req_ext, ptr_ext, NUM_AGENTS);
        vld                     = pick.vld;
        idx                     = pick.idx[IDX_W-1:0];
    end

    assign unused_idx_hi = ^pick.idx;

endmodule

// File: rtl/arb_rr.sv
// Round-robin arbiter with grant hold: the owner keeps the grant for up to
// MAX_HOLD consecutive cycles while others request, indefinitely otherwise.
module arb_rr
    import arb_pkg::*;
#(
    parameter  int NUM_AGENTS = NUM_AGENTS_DEF,
    parameter  int MAX_HOLD   = MAX_HOLD_DEF,
    localparam int IDX_W      = $clog2(NUM_AGENTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_AGENTS-1:0] req,
    output logic [NUM_AGENTS-1:0] ack,
    output logic                  ack_vld,
    output logic [IDX_W-1:0]      ack_idx
);

    localparam int               CNT_W     = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(NUM_AGENTS - 1);

    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      owner;
    logic                  locked;
    logic [CNT_W-1:0]      hold_cnt;

    agent_vec_t            owner_oh_ext;
    agent_vec_t            grant_oh_ext;
    logic [NUM_AGENTS-1:0] owner_oh;
    logic [NUM_AGENTS-1:0] others;
    logic                  below_last;
    logic                  keep;
    logic                  pick_vld;
    logic [IDX_W-1:0]      pick_idx;
    logic                  grant_vld;
    logic [IDX_W-1:0]      grant_idx;
    logic                  unused_oh_hi;

    arb_rr_pick #(
        .NUM_AGENTS (NUM_AGENTS)
    ) u_pick (
        .req (req),
        .ptr (rr_ptr),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    // Hold decision; hold_cnt never exceeds HOLD_LAST, so inequality means "below the limit".
    always_comb begin
        owner_oh_ext = onehot(agent_idx_t'(owner));
        owner_oh     = owner_oh_ext[NUM_AGENTS-1:0];
        others       = req & ~owner_oh;
        below_last   = (hold_cnt != HOLD_LAST);
        keep         = locked & req[owner] & (below_last | (others == '0));
    end

    // Grant selection; rst forces an idle grant regardless of req.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (rst) begin
            grant_vld = 1'b0;
            grant_idx = '0;
        end else if (keep) begin
            grant_vld = 1'b1;
            grant_idx = owner;
        end else if (pick_vld) begin
            grant_vld = 1'b1;
            grant_idx = pick_idx;
        end else begin
            grant_vld = 1'b0;
            grant_idx = '0;
        end
        grant_oh_ext = onehot(agent_idx_t'(grant_idx));
        ack          = grant_vld ? grant_oh_ext[NUM_AGENTS-1:0] : '0;
    end

    assign ack_vld      = grant_vld;
    assign ack_idx      = grant_idx;
    assign unused_oh_hi = ^{owner_oh_ext, grant_oh_ext};

    // Owner, pointer and hold counter update.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= PTR_RST;
            owner    <= '0;
            locked   <= 1'b0;
            hold_cnt <= '0;
        end else if (grant_vld) begin
            if (keep) begin
                if (below_last) begin
                    hold_cnt <= hold_cnt + CNT_W'(1);
                end else begin
                    hold_cnt <= hold_cnt;
                end
            end else begin
                owner    <= grant_idx;
                rr_ptr   <= grant_idx;
                locked   <= 1'b1;
                hold_cnt <= '0;
            end
        end else begin
            locked   <= 1'b0;
            hold_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_arb_rr.sv
// Directed bench for arb_rr: a 2-agent/MAX_HOLD=4 instance and a
// 4-agent/MAX_HOLD=1 instance, plus per-cycle invariant monitoring.
module tb_arb_rr;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [1:0] req2     = 2'b00;
    logic [1:0] ack2;
    logic       ack_vld2;
    logic       ack_idx2;
    logic [3:0] req4     = 4'b0000;
    logic [3:0] ack4;
    logic       ack_vld4;
    logic [1:0] ack_idx4;

    int         checks   = 0;
    int         errors   = 0;
    int         run_len  = 0;
    logic [1:0] last_ack = 2'b00;
    int         wait0    = 0;
    int         wait1    = 0;

    always #5 clk = ~clk;

    arb_rr #(.NUM_AGENTS(2), .MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req2),
        .ack     (ack2),
        .ack_vld (ack_vld2),
        .ack_idx (ack_idx2)
    );

    arb_rr #(.NUM_AGENTS(4), .MAX_HOLD(1)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .req     (req4),
        .ack     (ack4),
        .ack_vld (ack_vld4),
        .ack_idx (ack_idx4)
    );

    // Invariants: one-hot-or-zero, subset of req, hold limit and starvation bound.
    always @(negedge clk) begin
        if (rst) begin
            run_len = 0;
            wait0   = 0;
            wait1   = 0;
        end else begin
            checks++;
            if (!$onehot0(ack2) || ((ack2 & ~req2) != 2'b00) || !$onehot0(ack4) || ((ack4 & ~req4) != 4'b0000)) begin
                errors++;
                $display("FAIL inv_onehot_subset ack2=%b req2=%b ack4=%b req4=%b", ack2, req2, ack4, req4);
            end
            if (ack_vld2 && ((req2 & ~ack2) != 2'b00)) begin
                run_len = (ack2 == last_ack && run_len > 0) ? run_len + 1 : 1;
            end else begin
                run_len = 0;
            end
            last_ack = ack2;
            wait0 = (req2[0] && !ack2[0]) ? wait0 + 1 : 0;
            wait1 = (req2[1] && !ack2[1]) ? wait1 + 1 : 0;
            checks++;
            if (run_len > 4) begin
                errors++;
                $display("FAIL inv_hold_limit run=%0d required<=4", run_len);
            end
            checks++;
            if (wait0 > 4 || wait1 > 4) begin
                errors++;
                $display("FAIL inv_starvation wait0=%0d wait1=%0d required<=4", wait0, wait1);
            end
        end
    end

    task automatic step(input logic r, input logic [1:0] q2, input logic [3:0] q4);
        @(posedge clk);
        #1;
        rst  = r;
        req2 = q2;
        req4 = q4;
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 2'b00, 4'b0000);
    endtask

    task automatic test_reset();
        step(1'b1, 2'b11, 4'b1111);
        checks += 4;
        if (ack2 !== 2'b00) begin errors++; $display("FAIL reset_ack got=%b exp=00", ack2); end
        if (ack_vld2 !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", ack_vld2); end
        if (ack_idx2 !== 1'b0) begin errors++; $display("FAIL reset_idx got=%b exp=0", ack_idx2); end
        if (ack4 !== 4'b0000) begin errors++; $display("FAIL reset_ack4 got=%b exp=0000", ack4); end
        do_reset();
    endtask

    task automatic test_single();
        step(1'b0, 2'b01, 4'b0000);
        checks += 3;
        if (ack2 !== 2'b01) begin errors++; $display("FAIL single_ack got=%b exp=01", ack2); end
        if (ack_idx2 !== 1'b0) begin errors++; $display("FAIL single_idx got=%b exp=0", ack_idx2); end
        if (ack_vld2 !== 1'b1) begin errors++; $display("FAIL single_vld got=%b exp=1", ack_vld2); end
        step(1'b0, 2'b00, 4'b0000);
        checks += 2;
        if (ack2 !== 2'b00) begin errors++; $display("FAIL idle_ack got=%b exp=00", ack2); end
        if (ack_vld2 !== 1'b0) begin errors++; $display("FAIL idle_vld got=%b exp=0", ack_vld2); end
        step(1'b0, 2'b01, 4'b0000);
        checks++;
        if (ack2 !== 2'b01) begin errors++; $display("FAIL rereq_ack got=%b exp=01", ack2); end
    endtask

    task automatic test_contention();
        logic [1:0] exp;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 2'b11, 4'b0000);
            exp = (((i / 4) % 2) == 0) ? 2'b01 : 2'b10;
            checks += 2;
            if (ack2 !== exp) begin errors++; $display("FAIL contention_ack[%0d] got=%b exp=%b", i, ack2, exp); end
            if (ack_idx2 !== exp[1]) begin errors++; $display("FAIL contention_idx[%0d] got=%b exp=%b", i, ack_idx2, exp[1]); end
        end
    endtask

    task automatic test_hold_contender();
        logic [1:0] exp;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 2'b10, 4'b0000);
            checks++;
            if (ack2 !== 2'b10) begin errors++; $display("FAIL uncontested[%0d] got=%b exp=10", i, ack2); end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 2'b11, 4'b0000);
            exp = (i < 4) ? 2'b01 : 2'b10;
            checks++;
            if (ack2 !== exp) begin errors++; $display("FAIL contender[%0d] got=%b exp=%b", i, ack2, exp); end
        end
    endtask

    task automatic test_owner_release();
        logic [1:0] exp;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 2'b11, 4'b0000);
            checks++;
            if (ack2 !== 2'b01) begin errors++; $display("FAIL release_pre[%0d] got=%b exp=01", i, ack2); end
        end
        step(1'b0, 2'b10, 4'b0000);
        checks++;
        if (ack2 !== 2'b10) begin errors++; $display("FAIL release_move got=%b exp=10", ack2); end
        // New owner starts its hold window from zero.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b11, 4'b0000);
            exp = (i < 3) ? 2'b10 : 2'b01;
            checks++;
            if (ack2 !== exp) begin errors++; $display("FAIL release_post[%0d] got=%b exp=%b", i, ack2, exp); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 2'b11, 4'b0000);
        end
        checks++;
        if (ack2 !== 2'b10) begin errors++; $display("FAIL mid_owner got=%b exp=10", ack2); end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 2'b11, 4'b0000);
            checks += 2;
            if (ack2 !== 2'b00) begin errors++; $display("FAIL mid_rst_ack[%0d] got=%b exp=00", i, ack2); end
            if (ack_vld2 !== 1'b0) begin errors++; $display("FAIL mid_rst_vld[%0d] got=%b exp=0", i, ack_vld2); end
        end
        step(1'b0, 2'b11, 4'b0000);
        checks++;
        if (ack2 !== 2'b01) begin errors++; $display("FAIL mid_after got=%b exp=01", ack2); end
    endtask

    task automatic test_rr4();
        logic [3:0] exp_all [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] exp_sub [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 2'b00, 4'b1111);
            checks++;
            if (ack4 !== exp_all[i]) begin errors++; $display("FAIL rr4_all[%0d] got=%b exp=%b", i, ack4, exp_all[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b00, 4'b1010);
            checks++;
            if (ack4 !== exp_sub[i]) begin errors++; $display("FAIL rr4_skip[%0d] got=%b exp=%b", i, ack4, exp_sub[i]); end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 2'b00, 4'b0100);
            checks += 2;
            if (ack4 !== 4'b0100) begin errors++; $display("FAIL rr4_solo[%0d] got=%b exp=0100", i, ack4); end
            if (ack_idx4 !== 2'd2) begin errors++; $display("FAIL rr4_solo_idx[%0d] got=%0d exp=2", i, ack_idx4); end
        end
        step(1'b0, 2'b00, 4'b0000);
        checks += 2;
        if (ack4 !== 4'b0000) begin errors++; $display("FAIL rr4_idle got=%b exp=0000", ack4); end
        if (ack_vld4 !== 1'b0) begin errors++; $display("FAIL rr4_idle_vld got=%b exp=0", ack_vld4); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_hold_contender();
        test_owner_release();
        test_reset_mid();
        test_rr4();
        step(1'b0, 2'b00, 4'b0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
